// File: rtl/rf_pkg.sv
// Shared constants and the writeback request bundle
// for the register-file write-port controller.
package rf_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int STARVE_MAX_DEF = 4;
  localparam int FIFO_DEPTH = 2;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Two-entry buffer for long-latency results.
// Ports: clk, rst (sync, active-high),
//   push/push_req write side, pop pops head,
//   head_req = oldest entry, count = occupancy 0..2.
module rf_wb_fifo
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  wb_req_t    push_req,
  input  logic       pop,
  output wb_req_t    head_req,
  output logic [1:0] count
);

  wb_req_t mem [FIFO_DEPTH];
  logic    wr_ptr;
  logic    rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_req;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_req = mem[rd_ptr];

endmodule

// File: rtl/rf_wb_ctrl.sv
// Register-file write-port controller: merges the
// single-cycle ALU result (priority) with buffered
// long-latency (LU) results into one registered
// RegWrite/RD_Address/RDdata port. The LU head is
// protected from starvation by stalling the ALU after
// STARVE_MAX consecutive losses.
// Ports:
//   clk, rst             clock, sync active-high reset
//   ALU_Valid/RD/Data    ALU result, ALU_Stall = not taken
//   LU_Valid/RD/Data     LU result, LU_Ready handshake
//   RegWrite/RD_Address/RDdata  registered RF write port
//   WB_Idle              nothing buffered, no write
//   RS/RT_Address        forward compare addresses
//   RS/RT_Fwd_Hit/Data   forward of the write in flight
// Config macro: RF_WB_BYPASS_EN enables forwarding;
// when undefined the forward outputs are tied to 0.
module rf_wb_ctrl
  import rf_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ALU_Valid,
  input  logic [ADDR_W-1:0] ALU_RD,
  input  logic [DATA_W-1:0] ALU_Data,
  output logic              ALU_Stall,
  input  logic              LU_Valid,
  output logic              LU_Ready,
  input  logic [ADDR_W-1:0] LU_RD,
  input  logic [DATA_W-1:0] LU_Data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] RD_Address,
  output logic [DATA_W-1:0] RDdata,
  output logic              WB_Idle,
  input  logic [ADDR_W-1:0] RS_Address,
  input  logic [ADDR_W-1:0] RT_Address,
  output logic              RS_Fwd_Hit,
  output logic [DATA_W-1:0] RS_Fwd_Data,
  output logic              RT_Fwd_Hit,
  output logic [DATA_W-1:0] RT_Fwd_Data
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] S_MAX = SW'(STARVE_MAX);

  logic [1:0]    count;
  logic [SW-1:0] starve_cnt;
  wb_req_t       head_req;
  wb_req_t       push_req;
  logic          lu_pend;
  logic          lu_push;
  logic          alu_win;
  logic          lu_pop;

  assign lu_pend  = (count != 2'd0);
  // Ready from registered count only: no flow-through.
  assign LU_Ready = (count < 2'd2);
  assign lu_push  = LU_Valid && LU_Ready;

  // Pure decode of registered state.
  assign ALU_Stall = (starve_cnt == S_MAX) && lu_pend;

  assign alu_win = ALU_Valid && !ALU_Stall;
  assign lu_pop  = !alu_win && lu_pend;

  assign WB_Idle = !lu_pend && !RegWrite;

  assign push_req = '{rd: LU_RD, data: LU_Data};

  rf_wb_fifo u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (lu_push),
    .push_req (push_req),
    .pop      (lu_pop),
    .head_req (head_req),
    .count    (count)
  );

  // Write port. A $0 destination still wins the
  // slot but leaves RegWrite low.
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWrite   <= 1'b0;
      RD_Address <= REG_ZERO;
      RDdata     <= '0;
    end else begin
      unique case (1'b1)
        alu_win: begin
          RegWrite   <= (ALU_RD != REG_ZERO);
          RD_Address <= ALU_RD;
          RDdata     <= ALU_Data;
        end
        lu_pop: begin
          RegWrite   <= (head_req.rd != REG_ZERO);
          RD_Address <= head_req.rd;
          RDdata     <= head_req.data;
        end
        default: begin
          RegWrite <= 1'b0;
        end
      endcase
    end
  end

  // Counts ALU wins over a waiting LU head.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (lu_pop) begin
      starve_cnt <= '0;
    end else if (alu_win && lu_pend &&
                 starve_cnt != S_MAX) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

`ifdef RF_WB_BYPASS_EN
  assign RS_Fwd_Hit  = RegWrite &&
                       (RD_Address == RS_Address) &&
                       (RS_Address != REG_ZERO);
  assign RT_Fwd_Hit  = RegWrite &&
                       (RD_Address == RT_Address) &&
                       (RT_Address != REG_ZERO);
  assign RS_Fwd_Data = RDdata;
  assign RT_Fwd_Data = RDdata;
`else
  logic unused_fwd_addr;
  assign unused_fwd_addr = ^{RS_Address, RT_Address};
  assign RS_Fwd_Hit  = 1'b0;
  assign RT_Fwd_Hit  = 1'b0;
  assign RS_Fwd_Data = '0;
  assign RT_Fwd_Data = '0;
`endif

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Scoreboard bench for rf_wb_ctrl: directed scenarios
// plus randomized traffic against a queue-based model.
module tb_rf_wb_ctrl;
  import rf_pkg::*;

  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ALU_Valid = 1'b0;
  logic [4:0]  ALU_RD = '0;
  logic [31:0] ALU_Data = '0;
  logic        ALU_Stall;
  logic        LU_Valid = 1'b0;
  logic        LU_Ready;
  logic [4:0]  LU_RD = '0;
  logic [31:0] LU_Data = '0;
  logic        RegWrite;
  logic [4:0]  RD_Address;
  logic [31:0] RDdata;
  logic        WB_Idle;
  logic [4:0]  RS_Address = '0;
  logic [4:0]  RT_Address = '0;
  logic        RS_Fwd_Hit;
  logic [31:0] RS_Fwd_Data;
  logic        RT_Fwd_Hit;
  logic [31:0] RT_Fwd_Data;

  int errors = 0;
  int checks = 0;

  // Reference model state
  wb_req_t     mq[$];
  wb_req_t     expq[$];
  int          m_starve = 0;
  bit          m_we = 0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_data = '0;
  bit          run = 0;

  rf_wb_ctrl #(.STARVE_MAX(SMAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .ALU_Valid   (ALU_Valid),
    .ALU_RD      (ALU_RD),
    .ALU_Data    (ALU_Data),
    .ALU_Stall   (ALU_Stall),
    .LU_Valid    (LU_Valid),
    .LU_Ready    (LU_Ready),
    .LU_RD       (LU_RD),
    .LU_Data     (LU_Data),
    .RegWrite    (RegWrite),
    .RD_Address  (RD_Address),
    .RDdata      (RDdata),
    .WB_Idle     (WB_Idle),
    .RS_Address  (RS_Address),
    .RT_Address  (RT_Address),
    .RS_Fwd_Hit  (RS_Fwd_Hit),
    .RS_Fwd_Data (RS_Fwd_Data),
    .RT_Fwd_Hit  (RT_Fwd_Hit),
    .RT_Fwd_Data (RT_Fwd_Data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Drive one cycle, advance the model across the
  // posedge, return #1 after the edge.
  task automatic step(input bit r,
                      input bit av,
                      input logic [4:0] ard,
                      input logic [31:0] ad,
                      input bit lv,
                      input logic [4:0] lrd,
                      input logic [31:0] ld,
                      output bit stalled);
    bit stall;
    bit rdy;
    wb_req_t h;
    rst = r;
    ALU_Valid = av;
    ALU_RD = ard;
    ALU_Data = ad;
    LU_Valid = lv;
    LU_RD = lrd;
    LU_Data = ld;
    RS_Address = 5'($urandom_range(0, 7));
    RT_Address = 5'($urandom_range(0, 7));
    stall = (m_starve == SMAX) && (mq.size() > 0);
    rdy = (mq.size() < 2);
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_starve = 0;
      m_we = 0;
      m_rd = '0;
      m_data = '0;
    end else begin
      if (av && !stall) begin
        m_we = (ard != 0);
        m_rd = ard;
        m_data = ad;
        if (mq.size() > 0 && m_starve < SMAX)
          m_starve++;
      end else if (mq.size() > 0) begin
        h = mq.pop_front();
        m_we = (h.rd != 0);
        m_rd = h.rd;
        m_data = h.data;
        m_starve = 0;
      end else begin
        m_we = 0;
      end
      if (lv && rdy)
        mq.push_back('{rd: lrd, data: ld});
      if (m_we)
        expq.push_back('{rd: m_rd, data: m_data});
    end
    stalled = stall;
    #1;
  endtask

  task automatic idle(input int n);
    bit s;
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 0, 0, 0, 0, s);
  endtask

  // Monitor: pops the scoreboard on each write and
  // checks status outputs against the model.
  always @(negedge clk) begin
    wb_req_t e;
    bit hs, ht;
    if (run) begin
      chk("regwrite", {31'd0, RegWrite}, {31'd0, m_we});
      if (m_we) begin
        if (expq.size() == 0) begin
          chk("sb_empty", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("wr_rd", {27'd0, RD_Address}, {27'd0, e.rd});
          chk("wr_data", RDdata, e.data);
        end
      end
      chk("alu_stall", {31'd0, ALU_Stall},
          {31'd0, (m_starve == SMAX && mq.size() > 0)});
      chk("lu_ready", {31'd0, LU_Ready},
          {31'd0, (mq.size() < 2)});
      chk("wb_idle", {31'd0, WB_Idle},
          {31'd0, (mq.size() == 0 && !m_we)});
`ifdef RF_WB_BYPASS_EN
      hs = m_we && m_rd == RS_Address && RS_Address != 0;
      ht = m_we && m_rd == RT_Address && RT_Address != 0;
      chk("rs_hit", {31'd0, RS_Fwd_Hit}, {31'd0, hs});
      chk("rt_hit", {31'd0, RT_Fwd_Hit}, {31'd0, ht});
      if (hs) chk("rs_data", RS_Fwd_Data, m_data);
      if (ht) chk("rt_data", RT_Fwd_Data, m_data);
`else
      hs = 0;
      ht = 0;
      chk("rs_hit", {31'd0, RS_Fwd_Hit}, {31'd0, hs});
      chk("rt_hit", {31'd0, RT_Fwd_Hit}, {31'd0, ht});
      chk("rs_data", RS_Fwd_Data, 0);
      chk("rt_data", RT_Fwd_Data, 0);
`endif
    end
  end

  initial begin
    bit s;
    bit pv;
    logic [4:0] prd;
    logic [31:0] pd;

    // Reset state
    step(1, 0, 0, 0, 0, 0, 0, s);
    run = 1;
    chk("rst_we", {31'd0, RegWrite}, 0);
    chk("rst_rd", {27'd0, RD_Address}, 0);
    chk("rst_data", RDdata, 0);
    chk("rst_ready", {31'd0, LU_Ready}, 1);
    chk("rst_stall", {31'd0, ALU_Stall}, 0);
    chk("rst_idle", {31'd0, WB_Idle}, 1);

    // 1: single ALU write, one-cycle latency
    step(0, 1, 5, 123, 0, 0, 0, s);
    chk("t1_we", {31'd0, RegWrite}, 1);
    chk("t1_rd", {27'd0, RD_Address}, 5);
    chk("t1_data", RDdata, 123);
    idle(1);
    chk("t1_we0", {31'd0, RegWrite}, 0);

    // 2: two LU results, written in order
    step(0, 0, 0, 0, 1, 7, 32'hAA, s);
    chk("t2_nowr", {31'd0, RegWrite}, 0);
    step(0, 0, 0, 0, 1, 8, 32'hBB, s);
    chk("t2_rd7", {27'd0, RD_Address}, 7);
    chk("t2_d7", RDdata, 32'hAA);
    idle(1);
    chk("t2_rd8", {27'd0, RD_Address}, 8);
    chk("t2_d8", RDdata, 32'hBB);
    idle(1);
    chk("t2_idle", {31'd0, WB_Idle}, 1);

    // 3: starvation guard
    step(0, 1, 3, 100, 1, 9, 32'h55, s);
    for (int k = 1; k <= 4; k++) begin
      step(0, 1, 3, 32'(100 + k), 0, 0, 0, s);
      chk("t3_stall", {31'd0, ALU_Stall},
          (k == 4) ? 32'd1 : 32'd0);
    end
    step(0, 1, 3, 200, 0, 0, 0, s);
    chk("t3_lu_rd", {27'd0, RD_Address}, 9);
    chk("t3_lu_d", RDdata, 32'h55);
    step(0, 1, 3, 200, 0, 0, 0, s);
    chk("t3_alu_rd", {27'd0, RD_Address}, 3);
    chk("t3_alu_d", RDdata, 200);
    idle(1);

    // 4: writes to $0 are dropped
    step(0, 1, 0, 32'hFFFF, 0, 0, 0, s);
    chk("t4_alu0", {31'd0, RegWrite}, 0);
    step(0, 0, 0, 0, 1, 0, 32'h1234, s);
    idle(1);
    chk("t4_lu0", {31'd0, RegWrite}, 0);
    chk("t4_idle", {31'd0, WB_Idle}, 1);

    // 5: buffer full, then reset mid-operation
    step(0, 1, 3, 1, 1, 10, 32'hA0, s);
    step(0, 1, 4, 2, 1, 11, 32'hB0, s);
    chk("t5_full", {31'd0, LU_Ready}, 0);
    step(1, 0, 0, 0, 0, 0, 0, s);
    chk("t5_we", {31'd0, RegWrite}, 0);
    chk("t5_ready", {31'd0, LU_Ready}, 1);
    chk("t5_idle", {31'd0, WB_Idle}, 1);
    idle(3);
    chk("t5_stale", {31'd0, RegWrite}, 0);

    // Random traffic; a stalled ALU result is held
    s = 0;
    pv = 0;
    prd = '0;
    pd = '0;
    for (int i = 0; i < 3000; i++) begin
      bit r;
      r = ($urandom_range(0, 299) == 0);
      if (!(pv && s) || r) begin
        pv = ($urandom_range(0, 9) < 6);
        prd = 5'($urandom_range(0, 7));
        pd = $urandom;
      end
      step(r, pv, prd, pd,
           ($urandom_range(0, 1) == 1),
           5'($urandom_range(0, 7)), $urandom, s);
    end

    // Drain
    for (int i = 0; i < 10 && mq.size() > 0; i++)
      idle(1);
    idle(2);
    chk("drain_mq", mq.size(), 0);
    chk("drain_sb", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
